// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: widths and FSM state encodings.
package div_unit_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = 6;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Divide request/response bundle between the execute stage (master) and the divider (slave).
interface div_unit_if
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);
   logic             div_enable;
   logic             div_sign;
   logic [WIDTH-1:0] div_src1;
   logic [WIDTH-1:0] div_src2;
   logic             div_ack;
   logic             div_complete;
   logic [WIDTH-1:0] div_quotient;
   logic [WIDTH-1:0] div_remainder;

   modport master (
      output div_enable, div_sign, div_src1, div_src2, div_ack,
      input  div_complete, div_quotient, div_remainder
   );

   modport slave (
      input  div_enable, div_sign, div_src1, div_src2, div_ack,
      output div_complete, div_quotient, div_remainder
   );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on a magnitude {rem, quo} pair.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvsr_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);
   logic [WIDTH:0] rem_sh_s;
   logic [WIDTH:0] trial_s;

   assign rem_sh_s = {rem_i, quo_i[WIDTH-1]};
   // Extra top bit of the trial difference carries the borrow.
   assign trial_s  = rem_sh_s - {1'b0, dvsr_i};

   // Keep the difference when it did not borrow, otherwise restore.
   always_comb begin
      rem_o = rem_sh_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
      if (!trial_s[WIDTH]) begin
         rem_o = trial_s[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = rem_sh_s[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu; result held until the execute stage acks.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration when |dividend| < |divisor|.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   div_unit_if.slave  dif
);
   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             complete_q, complete_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;

   logic [WIDTH-1:0] mag1_s, mag2_s;
   logic [WIDTH-1:0] step_rem_s, step_quo_s;
   logic             msb1_s, msb2_s;
   logic             early_s;

   assign msb1_s = dif.div_src1[WIDTH-1];
   assign msb2_s = dif.div_src2[WIDTH-1];
   assign mag1_s = (dif.div_sign && msb1_s) ? (~dif.div_src1 + 1'b1) : dif.div_src1;
   assign mag2_s = (dif.div_sign && msb2_s) ? (~dif.div_src2 + 1'b1) : dif.div_src2;

`ifdef DIV_EARLY_OUT_EN
   assign early_s = (mag2_s != '0) && (mag1_s < mag2_s);
`else
   assign early_s = 1'b0;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i  (rem_q),
      .quo_i  (quo_q),
      .dvsr_i (dvsr_q),
      .rem_o  (step_rem_s),
      .quo_o  (step_quo_s)
   );

   // Next-state and datapath updates for the IDLE/CALC/FIX/DONE sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvsr_d      = dvsr_q;
      negq_d      = negq_q;
      negr_d      = negr_q;
      complete_d  = complete_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      case (state_q)
         DIV_IDLE: begin
            complete_d = 1'b0;
            if (dif.div_enable) begin
               dvsr_d = mag2_s;
               // A zero divisor keeps the all-ones quotient unnegated.
               negq_d = dif.div_sign & (msb1_s ^ msb2_s) & (dif.div_src2 != '0);
               negr_d = dif.div_sign & msb1_s;
               cnt_d  = '0;
               if (early_s) begin
                  rem_d   = mag1_s;
                  quo_d   = '0;
                  state_d = DIV_FIX;
               end else begin
                  rem_d   = '0;
                  quo_d   = mag1_s;
                  state_d = DIV_CALC;
               end
            end else begin
               state_d = DIV_IDLE;
            end
         end
         DIV_CALC: begin
            if (!dif.div_enable) begin
               state_d = DIV_IDLE;
            end else begin
               rem_d = step_rem_s;
               quo_d = step_quo_s;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = DIV_FIX;
               end else begin
                  state_d = DIV_CALC;
               end
            end
         end
         DIV_FIX: begin
            if (!dif.div_enable) begin
               state_d = DIV_IDLE;
            end else begin
               quotient_d  = negq_q ? (~quo_q + 1'b1) : quo_q;
               remainder_d = negr_q ? (~rem_q + 1'b1) : rem_q;
               complete_d  = 1'b1;
               state_d     = DIV_DONE;
            end
         end
         DIV_DONE: begin
            if (dif.div_ack) begin
               complete_d = 1'b0;
               state_d    = DIV_IDLE;
            end else begin
               state_d = DIV_DONE;
            end
         end
         default: begin
            complete_d = 1'b0;
            state_d    = DIV_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= DIV_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvsr_q      <= '0;
         negq_q      <= 1'b0;
         negr_q      <= 1'b0;
         complete_q  <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvsr_q      <= dvsr_d;
         negq_q      <= negq_d;
         negr_q      <= negr_d;
         complete_q  <= complete_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign dif.div_complete  = complete_q;
   assign dif.div_quotient  = quotient_q;
   assign dif.div_remainder = remainder_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized divides vs. an arithmetic model.
module tb_div_unit;
   localparam int W = 32;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   div_unit_if #(.WIDTH(W)) dif ();

   div_unit #(.WIDTH(W), .CNT_W(6)) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .dif   (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Architectural result: signed/unsigned truncating division, divide-by-zero rule.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                   output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      if (b == '0) begin
         q = '1;
         r = a;
      end else begin
         q = W'(sa / sb);
         r = W'(sa % sb);
      end
      lat = W + 1;
`ifdef DIV_EARLY_OUT_EN
      if (b != '0) begin
         if (sa < 0) sa = -sa;
         if (sb < 0) sb = -sb;
         if (sa < sb) lat = 1;
      end
`endif
   endfunction

   // Drives a divide at the current negedge, waits for completion, holds off ack, then acks.
   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int ack_delay);
      logic [W-1:0] eq, er;
      int lat, cnt;
      bit held;
      ref_div(a, b, s, eq, er, lat);
      dif.div_enable = 1'b1;
      dif.div_sign   = s;
      dif.div_src1   = a;
      dif.div_src2   = b;
      dif.div_ack    = 1'b0;
      cnt = 0;
      while (1) begin
         @(negedge clk);
         if (dif.div_complete === 1'b1 || cnt > 100) break;
         cnt++;
      end
      check_eq($sformatf("latency %0h/%0h s%0d", a, b, s), 64'(cnt), 64'(lat));
      check_eq($sformatf("quot %0h/%0h s%0d", a, b, s), 64'(dif.div_quotient), 64'(eq));
      check_eq($sformatf("rem %0h/%0h s%0d", a, b, s), 64'(dif.div_remainder), 64'(er));
      held = 1'b1;
      for (int i = 0; i < ack_delay; i++) begin
         @(negedge clk);
         if (dif.div_complete !== 1'b1 || dif.div_quotient !== eq) held = 1'b0;
      end
      check_eq("complete held until ack", 64'(held), 64'd1);
      dif.div_ack = 1'b1;
      @(negedge clk);
      dif.div_ack    = 1'b0;
      dif.div_enable = 1'b0;
      check_eq("complete drops after ack", 64'(dif.div_complete), 64'd0);
      check_eq("quot kept after ack", 64'(dif.div_quotient), 64'(eq));
   endtask

   initial begin
      logic [W-1:0] ra, rb, keep_q;
      logic         rs;
      bit           never;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      dif.div_enable = 1'b0;
      dif.div_sign   = 1'b0;
      dif.div_src1   = '0;
      dif.div_src2   = '0;
      dif.div_ack    = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("reset complete", 64'(dif.div_complete), 64'd0);
      check_eq("reset quot", 64'(dif.div_quotient), 64'd0);
      check_eq("reset rem", 64'(dif.div_remainder), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_div(32'd100, 32'd7, 1'b0, 2);
      do_div(32'hFFFFFF9C, 32'd7, 1'b1, 0);
      do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1);
      do_div(32'h12345678, 32'd0, 1'b1, 0);
      do_div(32'h87654321, 32'd0, 1'b0, 0);
      do_div(32'd1000, 32'd33, 1'b1, 5);
      do_div(32'hFFFFFFFF, 32'h10, 1'b0, 0);
      do_div(32'd3, 32'd9, 1'b0, 1);

      // Abort at cycle 10: complete must never rise and outputs must not move.
      keep_q = dif.div_quotient;
      dif.div_enable = 1'b1;
      dif.div_sign   = 1'b0;
      dif.div_src1   = 32'd5000;
      dif.div_src2   = 32'd3;
      repeat (10) @(negedge clk);
      dif.div_enable = 1'b0;
      never = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (dif.div_complete !== 1'b0) never = 1'b0;
      end
      check_eq("abort no complete", 64'(never), 64'd1);
      check_eq("abort quot unchanged", 64'(dif.div_quotient), 64'(keep_q));

      // Asynchronous reset mid-iteration.
      dif.div_enable = 1'b1;
      dif.div_src1   = 32'd77;
      dif.div_src2   = 32'd5;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async reset quot", 64'(dif.div_quotient), 64'd0);
      check_eq("async reset rem", 64'(dif.div_remainder), 64'd0);
      check_eq("async reset complete", 64'(dif.div_complete), 64'd0);
      dif.div_enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = W'($urandom_range(1, 20));
            2: ra = W'($urandom_range(0, 50));
            3: rb = ~W'($urandom_range(0, 5));
            default: ra = ra;
         endcase
         do_div(ra, rb, rs, int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
